// File: rtl/quad_pair_pkg.sv
// Shared definitions for the quad operand pair collector: default operand
// width, pair-sum width and the slot encoding used to sequence a group.
package quad_pair_pkg;

    localparam int QP_W  = 6;
    localparam int QP_SW = QP_W + 1;

    // Role of the operand accepted in the current beat of a group.
    typedef enum logic [1:0] {
        SLOT0 = 2'd0,
        SLOT1 = 2'd1,
        SLOT2 = 2'd2,
        SLOT3 = 2'd3
    } slot_t;

    // Advance to the next slot; SLOT3 wraps to SLOT0.
    function automatic slot_t slot_next(input slot_t s);
        logic [1:0] nxt;
        nxt = s + 2'd1;
        return slot_t'(nxt);
    endfunction

endpackage

// File: rtl/qp_pair_add.sv
// Unsigned W-bit + W-bit adder producing a full W+1-bit sum (no truncation).
module qp_pair_add
    import quad_pair_pkg::*;
#(
    parameter int W = QP_W
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W:0]   sum_o
);

    // Zero-extend both operands so the carry lands in the top bit.
    assign sum_o = {1'b0, a_i} + {1'b0, b_i};

endmodule

// File: rtl/quad_operand_pair_collect.sv
// Groups a stream of W-bit operands in fours and presents the two pair sums
// (op0+op1, op2+op3) in a one-entry output register for the downstream
// fast adder. Optional short-group flush is enabled with QUAD_PAIR_FLUSH_EN,
// which adds the in_last port.
module quad_operand_pair_collect
    import quad_pair_pkg::*;
#(
    parameter int W = QP_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
`ifdef QUAD_PAIR_FLUSH_EN
    input  logic         in_last,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W:0]   out_a,
    output logic [W:0]   out_b,
    output logic         out_cin
);

    slot_t        slot_q,      slot_d;
    logic [W-1:0] op0_q,       op0_d;
    logic [W-1:0] op2_q,       op2_d;
    logic [W:0]   pa_q,        pa_d;
    logic [W:0]   out_a_q,     out_a_d;
    logic [W:0]   out_b_q,     out_b_d;
    logic         out_valid_q, out_valid_d;

    logic         is_last;
    logic         completing;
    logic         accept;
    logic [W:0]   pa_sum;
    logic [W:0]   pb_sum;
    logic [W:0]   new_a;
    logic [W:0]   new_b;

`ifdef QUAD_PAIR_FLUSH_EN
    assign is_last = in_last;
`else
    assign is_last = 1'b0;
`endif

    // A beat completes the group at slot3, or at any slot when flagged last.
    assign completing = (slot_q == SLOT3) || is_last;

    // Only a completing beat against an occupied, non-draining output stalls.
    assign in_ready = !(completing && out_valid_q && !out_ready);
    assign accept   = in_valid && in_ready;

    // First pair: op0 + incoming operand (used at slot1, or flush at slot1).
    qp_pair_add #(.W(W)) u_pair_a (
        .a_i   (op0_q),
        .b_i   (in_data),
        .sum_o (pa_sum)
    );

    // Second pair: op2 + incoming operand (used on the slot3 beat).
    qp_pair_add #(.W(W)) u_pair_b (
        .a_i   (op2_q),
        .b_i   (in_data),
        .sum_o (pb_sum)
    );

    // Select the pair loaded by a completing beat; unfilled operands count as 0.
    always_comb begin
        new_a = pa_q;
        new_b = pb_sum;
`ifdef QUAD_PAIR_FLUSH_EN
        case (slot_q)
            SLOT0: begin
                new_a = {1'b0, in_data};
                new_b = '0;
            end
            SLOT1: begin
                new_a = pa_sum;
                new_b = '0;
            end
            SLOT2: begin
                new_a = pa_q;
                new_b = {1'b0, in_data};
            end
            default: begin
                new_a = pa_q;
                new_b = pb_sum;
            end
        endcase
`endif
    end

    // Next-state: operand capture per slot, output load and output drain.
    always_comb begin
        slot_d      = slot_q;
        op0_d       = op0_q;
        op2_d       = op2_q;
        pa_d        = pa_q;
        out_a_d     = out_a_q;
        out_b_d     = out_b_q;
        out_valid_d = out_valid_q;

        // Drain first so a same-cycle load below keeps out_valid high.
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (accept) begin
            if (completing) begin
                slot_d      = SLOT0;
                out_a_d     = new_a;
                out_b_d     = new_b;
                out_valid_d = 1'b1;
            end else begin
                slot_d = slot_next(slot_q);
                case (slot_q)
                    SLOT0:   op0_d = in_data;
                    SLOT1:   pa_d  = pa_sum;
                    SLOT2:   op2_d = in_data;
                    default: ;
                endcase
            end
        end
    end

    // State registers; reset discards any partial group and held pair.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q      <= SLOT0;
            op0_q       <= '0;
            op2_q       <= '0;
            pa_q        <= '0;
            out_a_q     <= '0;
            out_b_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            slot_q      <= slot_d;
            op0_q       <= op0_d;
            op2_q       <= op2_d;
            pa_q        <= pa_d;
            out_a_q     <= out_a_d;
            out_b_q     <= out_b_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_a     = out_a_q;
    assign out_b     = out_b_q;
    assign out_cin   = 1'b0;

endmodule

// File: doc/quad_operand_pair_collect.md
# quad_operand_pair_collect

Upstream feeder for the 7-bit fast adder in the six-bit four-input adder datapath. Accepts a stream of 6-bit operands over a valid/ready handshake and groups them in fours. For each group it forms the two 7-bit pair sums (op0+op1, op2+op3) and holds them in an output register. The downstream 7-bit fast adder combines the pair into the final 8-bit result.

## Interface
- W, default 6: operand width. Pair sums are W+1 bits.
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  upstream operand valid.
- in_ready  output  1  block can accept an operand this cycle.
- in_data  input  W  operand, unsigned.
- in_last  input  1  present only with QUAD_PAIR_FLUSH_EN; marks the final operand of a short group.
- out_valid  output  1  pair register holds a completed group.
- out_ready  input  1  downstream consumes the pair this cycle.
- out_a  output  W+1  op0+op1; drives the fast adder `a`.
- out_b  output  W+1  op2+op3; drives the fast adder `b`.
- out_cin  output  1  tied 0; drives the fast adder `cin`.

## Operation
- A transfer occurs when in_valid && in_ready at the clock edge. An output transfer occurs when out_valid && out_ready.
- Slot counter `slot` (0..3) selects the role of the accepted operand:
  - slot0: latch op0.
  - slot1: register pa = op0 + in_data (W+1 bits, no truncation).
  - slot2: latch op2.
  - slot3: completing beat; load out_a = pa and out_b = op2 + in_data, set out_valid, and return slot to 0.
- Arithmetic is unsigned and zero-extended. Maximum pair sum is 2·(2^W−1), which fits in W+1 bits, so overflow cannot occur.
- Output register is one entry deep. out_valid stays set until an output transfer occurs; out_a and out_b are stable while out_valid && !out_ready.
- Collection of the next group proceeds while the output is occupied. Only a completing beat stalls: in_ready = !(completing && out_valid && !out_ready).
- Simultaneous completing beat and output transfer in the same cycle: the new pair loads and out_valid stays 1. No bubble.
- Output transfer with no completing beat: out_valid clears.
- in_ready does not depend on in_valid. in_ready is 1 whenever no completing beat is pending against a full output.

## Timing
- Reset values: slot=0, out_valid=0, out_a=0, out_b=0, pa=0, op0=0, op2=0, in_ready=1, out_cin=0.
- Asserting rst_n low mid-group discards the partial group and any held pair. The first operand accepted after release is op0.
- Latency: out_valid rises on the cycle after the completing beat is accepted.
- Throughput: one operand per cycle sustained with out_ready=1, giving one group every 4 cycles.
- Downstream result is combinational from out_a/out_b: sum = out_a + out_b, 8 bits.

## Configuration
- QUAD_PAIR_FLUSH_EN defined:
  - in_last port exists. A beat with in_last is completing at any slot, and unfilled operands are treated as 0.
  - in_last at slot0: out_a = in_data, out_b = 0.
  - in_last at slot1: out_a = op0 + in_data, out_b = 0.
  - in_last at slot2: out_a = pa, out_b = in_data.
  - in_last at slot3: identical to a normal slot3 beat.
  - slot returns to 0 after any completing beat.
- QUAD_PAIR_FLUSH_EN undefined: no in_last port. Groups are always exactly four operands, and only slot3 completes.

## Structure
- Shared package quad_pair_pkg: default width constant QP_W=6, slot encoding typedef (SLOT0..SLOT3), derived width QP_SW=QP_W+1.
- One sub-module, qp_pair_add: W-bit + W-bit → W+1-bit unsigned adder. Instantiated twice: once for pa, once for out_b.
- Control logic (slot counter, stall, out_valid) stays in the top module.

## Test plan
- Operands 63,63,63,63 with out_ready=1 → one cycle after the 4th beat, out_valid=1, out_a=126, out_b=126, out_cin=0; downstream sum=252.
- Stream 1,2,3,4,5,6,7,8 back-to-back with out_ready=1 → pairs (3,7) then (11,15) on consecutive groups; in_ready never drops.
- out_ready=0 after the first group completes; feed 8 more operands → in_ready stays 1 through slot2 of the 2nd group and drops at its slot3 beat. Raise out_ready → first pair transfers, second pair loads in the same cycle, no data lost.
- rst_n pulsed low after 2 operands (10,20), then feed 1,1,1,1 → out_a=2, out_b=2; no residue of 10 or 20.
- With QUAD_PAIR_FLUSH_EN: 5,9,7 with in_last on 7 → out_a=14, out_b=7. A single operand 33 with in_last → out_a=33, out_b=0.
- Reset release: check all outputs hold their reset values before the first edge, and in_ready=1.
